fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
Time-multiplexed controller for the 10x10 fully connected stage. It runs one signed MAC instead of 100 parallel multipliers. It accepts the 10-word feature vector over a valid/ready stream and fetches weights from an external synchronous weight memory. It accumulates each output row, applies the fixed-point rescale (arithmetic >>14), and streams the 10 results out. It sits between the last pooling stage and the classifier output.

Parameters:
bitwidth, 32, width of feature, weight and result words (signed two's complement)
frac_shift, 14, arithmetic right-shift applied to each row accumulator
n_len, 10, vector length; the matrix is n_len x n_len

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new layer pass; sampled only in IDLE
busy  output  1  high in every state except IDLE
in_valid  input  1  feature word valid
in_ready  output  1  high only in LOAD
in_data  input  bitwidth  feature word; element 0 is sent first
weight_en  output  1  weight memory read enable
weight_addr  output  7  row-major weight address, j*n_len+i
weight_rdata  input  bitwidth  weight word, valid the cycle after weight_en
out_valid  output  1  result word valid
out_ready  input  1  downstream accepts the result word
out_data  output  bitwidth  result word
out_index  output  4  row index j of out_data
done  output  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, in_ready, weight_en, out_valid and done are 0. weight_addr, out_data and out_index are 0. Accumulator, counters and buffers are cleared.
- Reset asserted mid-operation aborts the pass immediately. No partial outputs are emitted after release.
- IDLE: start=1 moves to LOAD next cycle. start is ignored in all other states, with no queuing.
- LOAD: in_ready=1. Each in_valid&in_ready handshake stores in_data into fm[k], k=0..n_len-1. After the n_len-th handshake, next state is COMPUTE. Stalls indefinitely while in_valid=0.
- COMPUTE: issue cycles c=0..n_len*n_len-1 with weight_en=1 and weight_addr=c (row j=c/n_len, column i=c%n_len). This is a one-cycle-delayed pipeline. On cycle c+1, acc <= (i==0 ? 0 : acc) + fm[i]*weight_rdata.
- Accumulation: full 2*bitwidth signed product added into a 2*bitwidth accumulator, wrapping modulo 2^(2*bitwidth). There is no saturation.
- When the i==n_len-1 term is added, res[j] <= (acc_final >>> frac_shift) truncated to the low bitwidth bits.
- COMPUTE lasts n_len*n_len+1 cycles: 100 issue cycles plus 1 drain cycle with weight_en=0. It then moves to OUTPUT.
- OUTPUT: out_valid=1 with out_data=res[k] and out_index=k, k starting at 0.
- Output hold: out_data and out_index hold while out_ready=0. Each handshake advances k.
- After the handshake at k=n_len-1: out_valid=0, done=1 for exactly one cycle, then IDLE. start in that same cycle is ignored.
- Timing with in_valid and out_ready held high: start sampled at cycle 0, LOAD cycles 1..10, COMPUTE cycles 11..111, first out_valid at cycle 112, done at cycle 122.
- fm and res are internal registers. weight memory contents are never written by this block.

Test Plan:
- Identity scaling: all fm=16384, W[j][i]=16384 when i==j else 0, out_ready=1 -> out_data=16384 for j=0..9, out_index 0..9 in order, first out_valid at cycle 112, done at 122.
- Signed and rescale: fm[0]=-16384 and all other fm=0, W[j][0]=3*16384 -> every out_data=-49152. fm[i]=1, all W=1 -> every out_data=0 (10>>>14).
- Backpressure and stalls: in_valid toggled 1-0-1, out_ready low for 5 cycles at k=3 -> all feature words captured; out_data/out_index stable at res[3]/3 during the stall; the results sequence is unchanged.
- Address sequence: monitor weight_en/weight_addr -> exactly 100 consecutive reads, addresses 0..99 ascending, no read in the LOAD or OUTPUT states.
- Start while busy: pulse start during COMPUTE and on the done cycle -> no restart and no extra pass. A start one cycle after done begins a new pass, and the second pass results match the first.
- Reset mid-compute: drop rst_n at address 47 -> all outputs are 0 asynchronously. After release with busy=0, a new full pass gives correct results with no residual accumulator value.

Source files
------------

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: 10x10 fully connected layer on one signed MAC.
// Loads features, streams weights from a sync memory, emits rescaled rows.
module fc_layer_sequencer #(
  parameter int bitwidth   = 32,
  parameter int frac_shift = 14,
  parameter int n_len      = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bitwidth-1:0] in_data,
  output logic                weight_en,
  output logic [6:0]          weight_addr,
  input  logic [bitwidth-1:0] weight_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bitwidth-1:0] out_data,
  output logic [3:0]          out_index,
  output logic                done
);

  localparam int         aw    = 2 * bitwidth;
  localparam logic [6:0] n_mac = 7'(n_len * n_len);
  localparam logic [3:0] last  = 4'(n_len - 1);

  localparam logic [2:0] s_idle = 3'd0;
  localparam logic [2:0] s_load = 3'd1;
  localparam logic [2:0] s_comp = 3'd2;
  localparam logic [2:0] s_out  = 3'd3;
  localparam logic [2:0] s_done = 3'd4;

  logic [2:0]          state;
  logic [3:0]          k;
  logic [3:0]          i;
  logic [3:0]          j;
  logic [3:0]          i_d;
  logic [3:0]          j_d;
  logic [6:0]          c;
  logic                vld_d;
  logic [bitwidth-1:0] fm  [n_len];
  logic [bitwidth-1:0] res [n_len];
  logic [aw-1:0]       acc;
  logic [aw-1:0]       acc_nxt;
  logic signed [aw-1:0] fa;
  logic signed [aw-1:0] wa;
  logic signed [aw-1:0] prod;

  logic st_idle;
  logic st_load;
  logic st_comp;
  logic st_out;
  logic st_done;

  assign st_idle = (state == s_idle);
  assign st_load = (state == s_load);
  assign st_comp = (state == s_comp);
  assign st_out  = (state == s_out);
  assign st_done = (state == s_done);

  assign busy        = !st_idle;
  assign in_ready    = st_load;
  assign weight_en   = st_comp && (c != n_mac);
  assign weight_addr = weight_en ? c : '0;
  assign out_valid   = st_out;
  assign out_data    = st_out ? res[k] : '0;
  assign out_index   = st_out ? k : '0;
  assign done        = st_done;

  // Weight word lands one cycle after issue; i_d/j_d track that term.
  always_comb begin
    fa      = {{bitwidth{fm[i_d][bitwidth-1]}}, fm[i_d]};
    wa      = {{bitwidth{weight_rdata[bitwidth-1]}}, weight_rdata};
    prod    = fa * wa;
    acc_nxt = ((i_d == '0) ? '0 : acc) + prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= s_idle;
      k     <= '0;
      i     <= '0;
      j     <= '0;
      i_d   <= '0;
      j_d   <= '0;
      c     <= '0;
      vld_d <= 1'b0;
      acc   <= '0;
      for (int n = 0; n < n_len; n++) begin
        fm[n]  <= '0;
        res[n] <= '0;
      end
    end else begin
      vld_d <= 1'b0;
      unique case (1'b1)
        st_idle: begin
          if (start) begin
            state <= s_load;
            k     <= '0;
          end
        end
        st_load: begin
          if (in_valid) begin
            fm[k] <= in_data;
            if (k == last) begin
              k     <= '0;
              c     <= '0;
              i     <= '0;
              j     <= '0;
              state <= s_comp;
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        st_comp: begin
          if (c != n_mac) begin
            vld_d <= 1'b1;
            i_d   <= i;
            j_d   <= j;
            c     <= c + 7'd1;
            if (i == last) begin
              i <= '0;
              j <= j + 4'd1;
            end else begin
              i <= i + 4'd1;
            end
          end else begin
            state <= s_out;
          end
        end
        st_out: begin
          if (out_ready) begin
            if (k == last) begin
              k     <= '0;
              state <= s_done;
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        st_done: state <= s_idle;
        default: state <= s_idle;
      endcase
      if (vld_d) begin
        acc <= acc_nxt;
        if (i_d == last)
          res[j_d] <= acc_nxt[frac_shift+bitwidth-1 -: bitwidth];
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: randomized checks of fc_layer_sequencer
// against a plain-arithmetic matrix-vector reference model.
module tb_fc_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        weight_en;
  logic [6:0]  weight_addr;
  logic [31:0] weight_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        done;

  fc_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight_en(weight_en), .weight_addr(weight_addr),
    .weight_rdata(weight_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] wmem [100];
  logic [31:0] fmv  [10];
  logic [31:0] expv [10];
  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int rdq[$];
  int rdcyc[$];
  int badrd  = 0;

  // Synchronous weight memory plus read monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (weight_en) begin
      weight_rdata <= wmem[weight_addr];
      rdq.push_back(int'(weight_addr));
      rdcyc.push_back(cyc);
      if (in_ready || out_valid || done) badrd++;
    end
  end

  task automatic model();
    longint acc;
    logic [63:0] sh;
    for (int r = 0; r < 10; r++) begin
      acc = 0;
      for (int col = 0; col < 10; col++)
        acc += longint'($signed(fmv[col])) * longint'($signed(wmem[r*10+col]));
      sh = acc >>> 14;
      expv[r] = sh[31:0];
    end
  endtask

  task automatic rand_data();
    for (int a = 0; a < 100; a++) wmem[a] = $urandom;
    for (int a = 0; a < 10; a++) fmv[a] = $urandom;
    model();
  endtask

  task automatic start_feed(input bit toggle, output int t0);
    int idx;
    int n;
    bit hs;
    idx = 0;
    n = 0;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (idx < 10 && n < 200) begin
      in_valid = !(toggle && n[0]);
      in_data = fmv[idx];
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) idx++;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 10) begin
      errs++;
      $display("FAIL feed: accepted %0d words, required 10", idx);
    end
  endtask

  task automatic collect(input bit stall, input bit pulse_busy,
                         input bit pulse_done, input int t0,
                         output int t_first, output int t_done);
    int k;
    int n;
    int sc;
    bit hs;
    k = 0;
    n = 0;
    sc = 0;
    t_first = -1;
    t_done = -1;
    out_ready = 1'b1;
    while (k < 10 && n < 500) begin
      if (pulse_busy) start = weight_en && (weight_addr == 7'd50);
      hs = 1'b0;
      if (out_valid) begin
        if (t_first < 0) t_first = cyc - t0;
        checks++;
        if (out_data !== expv[k] || out_index !== 4'(k)) begin
          errs++;
          $display("FAIL result[%0d]: got data %0d index %0d, required data %0d index %0d",
                   k, $signed(out_data), out_index, $signed(expv[k]), k);
        end
        out_ready = !(stall && k == 3 && sc < 5);
        if (!out_ready) sc++;
        hs = out_ready;
      end
      @(negedge clk);
      if (hs) k++;
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (k != 10) begin
      checks++;
      errs++;
      $display("FAIL out_timeout: got %0d results, required 10", k);
      return;
    end
    t_done = cyc - t0;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL done_pulse: got done=%b out_valid=%b, required 1 0", done, out_valid);
    end
    if (pulse_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL post_done: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({busy, in_ready, weight_en, out_valid, done, weight_addr,
         out_data, out_index} !== '0) begin
      errs++;
      $display("FAIL %s: got busy=%b in_ready=%b wen=%b ov=%b done=%b addr=%0d data=%0d idx=%0d, required all 0",
               tag, busy, in_ready, weight_en, out_valid, done,
               weight_addr, out_data, out_index);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_reset");
  endtask

  task automatic test_identity();
    int t0, tf, td;
    for (int a = 0; a < 100; a++)
      wmem[a] = (a / 10 == a % 10) ? 32'd16384 : 32'd0;
    for (int a = 0; a < 10; a++) fmv[a] = 32'd16384;
    model();
    start_feed(1'b0, t0);
    collect(1'b0, 1'b0, 1'b0, t0, tf, td);
    checks++;
    if (tf !== 112) begin
      errs++;
      $display("FAIL first_valid_cycle: got %0d, required 112", tf);
    end
    checks++;
    if (td !== 122) begin
      errs++;
      $display("FAIL done_cycle: got %0d, required 122", td);
    end
  endtask

  task automatic test_signed();
    int t0, tf, td;
    for (int a = 0; a < 100; a++)
      wmem[a] = (a % 10 == 0) ? 32'd49152 : $urandom;
    for (int a = 0; a < 10; a++) fmv[a] = '0;
    fmv[0] = -32'sd16384;
    model();
    start_feed(1'b0, t0);
    collect(1'b0, 1'b0, 1'b0, t0, tf, td);
    for (int a = 0; a < 100; a++) wmem[a] = 32'd1;
    for (int a = 0; a < 10; a++) fmv[a] = 32'd1;
    model();
    start_feed(1'b0, t0);
    collect(1'b0, 1'b0, 1'b0, t0, tf, td);
  endtask

  task automatic test_backpressure();
    int t0, tf, td;
    rand_data();
    start_feed(1'b1, t0);
    collect(1'b1, 1'b0, 1'b0, t0, tf, td);
  endtask

  task automatic test_address();
    int t0, tf, td;
    bit ok;
    rand_data();
    rdq.delete();
    rdcyc.delete();
    badrd = 0;
    start_feed(1'b0, t0);
    collect(1'b0, 1'b0, 1'b0, t0, tf, td);
    ok = (rdq.size() == 100);
    if (ok)
      for (int a = 0; a < 100; a++)
        if (rdq[a] != a || rdcyc[a] != rdcyc[0] + a) ok = 0;
    checks++;
    if (!ok || badrd != 0) begin
      errs++;
      $display("FAIL addr_seq: got %0d reads, %0d outside compute, required 100 consecutive 0..99, 0 outside",
               rdq.size(), badrd);
    end
  endtask

  task automatic test_back_to_back();
    int t0, tf, td;
    rand_data();
    start_feed(1'b0, t0);
    collect(1'b0, 1'b1, 1'b1, t0, tf, td);
    start_feed(1'b0, t0);
    collect(1'b0, 1'b0, 1'b0, t0, tf, td);
  endtask

  task automatic test_reset_mid();
    int t0, tf, td, n;
    rand_data();
    start_feed(1'b0, t0);
    n = 0;
    while (!(weight_en && weight_addr == 7'd47) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errs++;
      $display("FAIL reach_addr47: got timeout, required read of address 47");
    end
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_release");
    rand_data();
    start_feed(1'b0, t0);
    collect(1'b0, 1'b0, 1'b0, t0, tf, td);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed();
    test_backpressure();
    test_address();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
